// File: rtl/shift_exec_stage_pkg.sv
// rtl/shift_exec_stage_pkg.sv - shared constants and types for the shift execute stage
package shift_exec_stage_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [4:0]          rd;
    logic                illegal;
  } entry_t;

endpackage

// File: rtl/barrel_shift_right.sv
// rtl/barrel_shift_right.sv - logarithmic right shifter, logical or arithmetic
module barrel_shift_right #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  shamt,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  logic            fill;
  logic [XLEN-1:0] stage [SHW+1];

  assign fill     = arith & data[XLEN-1];
  assign stage[0] = data;

  // Stage i shifts by 2**i when shamt[i] is set.
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stage[i+1] = shamt[i] ? {{S{fill}}, stage[i][XLEN-1:S]} : stage[i];
  end

  assign result = stage[SHW];

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - RV32I shift execute stage with a 2-entry skid buffer
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            is_imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [SHW-1:0]  imm_shamt,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  buf_state_t      state, state_next;
  entry_t          head, skid, incoming;
  logic            accept, retire;
  logic            is_left, is_right, illegal;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] rs1_rev, sh_in, sh_out, sh_out_rev;

  assign is_left  = (funct3 == F3_SLL) && !funct7_5;
  assign is_right = (funct3 == F3_SRL_SRA);
  assign illegal  = !(is_left || is_right);
  assign shamt    = is_imm ? imm_shamt : rs2_data[SHW-1:0];

  always_comb begin
    rs1_rev    = '0;
    sh_out_rev = '0;
    for (int i = 0; i < XLEN; i++) begin
      rs1_rev[i]    = rs1_data[XLEN-1-i];
      sh_out_rev[i] = sh_out[XLEN-1-i];
    end
  end

  // Left shifts reuse the right shifter on bit-reversed data.
  assign sh_in = is_left ? rs1_rev : rs1_data;

  barrel_shift_right #(.XLEN(XLEN), .SHW(SHW)) u_shift (
    .data   (sh_in),
    .shamt  (shamt),
    .arith  (is_right & funct7_5),
    .result (sh_out)
  );

  always_comb begin
    incoming         = '0;
    incoming.rd      = rd_addr;
    incoming.illegal = illegal;
    if (is_left)       incoming.result = sh_out_rev;
    else if (is_right) incoming.result = sh_out;
  end

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BUF_EMPTY: if (accept) state_next = BUF_ONE;
      BUF_ONE: begin
        if (accept && !retire)      state_next = BUF_FULL;
        else if (!accept && retire) state_next = BUF_EMPTY;
      end
      BUF_FULL:  if (retire) state_next = BUF_ONE;
      default:   state_next = BUF_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != BUF_FULL);
    out_valid = (state != BUF_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      case (state)
        BUF_EMPTY: if (accept) head <= incoming;
        BUF_ONE: begin
          if (accept && retire) head <= incoming;
          else if (accept)      skid <= incoming;
        end
        BUF_FULL:  if (retire) head <= skid;
        default: ;
      endcase
    end
  end

  assign out_result  = head.result;
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - randomized self-checking bench for shift_exec_stage
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        is_imm;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  imm_shamt;
  logic [4:0]  rd_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  shift_exec_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .is_imm     (is_imm),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm_shamt  (imm_shamt),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [2:0]  f3;
    bit        f7;
    bit        imm;
    bit [31:0] rs1;
    bit [31:0] rs2;
    bit [4:0]  ish;
    bit [4:0]  rd;
  } op_t;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  bit   hold = 0;
  logic [31:0] held_r;
  logic [4:0]  held_rd;
  logic        held_ill;
  op_t  idle_op = '{default: 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input bit [2:0] f3, input bit f7, input bit imm,
                             input bit [31:0] rs1, input bit [31:0] rs2,
                             input bit [4:0] ish, input bit [4:0] rd);
    op_t o;
    o.f3 = f3; o.f7 = f7; o.imm = imm; o.rs1 = rs1; o.rs2 = rs2; o.ish = ish; o.rd = rd;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    if ($urandom_range(0, 9) == 0) o.f3 = 3'($urandom);
    else                           o.f3 = $urandom_range(0, 1) ? 3'b001 : 3'b101;
    o.f7  = (o.f3 == 3'b001) ? ($urandom_range(0, 7) == 0) : 1'($urandom);
    o.imm = 1'($urandom);
    o.rs1 = $urandom;
    o.rs2 = $urandom;
    o.ish = 5'($urandom);
    o.rd  = 5'($urandom);
    return o;
  endfunction

  // Architectural meaning of each shift, straight from the ISA.
  function automatic exp_t model(input op_t o);
    exp_t e;
    int   sh;
    sh    = o.imm ? int'(o.ish) : int'(o.rs2 % 32);
    e.rd  = o.rd;
    e.ill = 1'b0;
    if (o.f3 == 3'b001 && !o.f7)  e.r = o.rs1 << sh;
    else if (o.f3 == 3'b101)      e.r = o.f7 ? 32'($signed(o.rs1) >>> sh) : (o.rs1 >> sh);
    else begin
      e.r   = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic cycle(input bit v, input op_t op, input bit ordy, output bit acc);
    @(negedge clk);
    in_valid  = v;
    funct3    = op.f3;
    funct7_5  = op.f7;
    is_imm    = op.imm;
    rs1_data  = op.rs1;
    rs2_data  = op.rs2;
    imm_shamt = op.ish;
    rd_addr   = op.rd;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() != 0);
    if (hold && out_valid) begin
      check("stable_result", out_result, held_r);
      check("stable_rd", out_rd, held_rd);
      check("stable_illegal", out_illegal, held_ill);
    end
    if (out_valid && q.size() != 0) begin
      check("result", out_result, q[0].r);
      check("rd", out_rd, q[0].rd);
      check("illegal", out_illegal, q[0].ill);
    end
    acc      = v && in_ready;
    hold     = out_valid && !ordy;
    held_r   = out_result;
    held_rd  = out_rd;
    held_ill = out_illegal;
    if (out_valid && ordy && q.size() != 0) void'(q.pop_front());
    if (acc) q.push_back(model(op));
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 10 && q.size() != 0; i++) cycle(0, idle_op, 1, a);
    cycle(0, idle_op, 1, a);
    check("drained", q.size(), 0);
  endtask

  task automatic directed(input string tag, input op_t op, input logic [31:0] exp_r);
    bit a;
    drain();
    cycle(1, op, 1, a);
    check({tag, "_accepted"}, a, 1);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_result, exp_r);
    check({tag, "_rd"}, out_rd, op.rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit a;
    op_t o;
    rst_n = 0; in_valid = 0; funct3 = 0; funct7_5 = 0; is_imm = 0;
    rs1_data = 0; rs2_data = 0; imm_shamt = 0; rd_addr = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_illegal", out_illegal, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);

    directed("srai", mk(3'b101, 1, 1, 32'h80000010, 32'h0, 5'd4, 5'd7), 32'hF8000001);
    directed("sll_rs2_high", mk(3'b001, 0, 0, 32'h1, 32'hFFFFFFE1, 5'd0, 5'd3), 32'h2);
    directed("srl_31", mk(3'b101, 0, 1, 32'h7AFAFAFA, 32'h0, 5'd31, 5'd9), 32'h0);
    directed("sra_31", mk(3'b101, 1, 0, 32'h80001234, 32'd31, 5'd0, 5'd1), 32'hFFFFFFFF);
    directed("shamt0", mk(3'b001, 0, 1, 32'hDEADBEEF, 32'h0, 5'd0, 5'd2), 32'hDEADBEEF);
    directed("srl_rs2_21", mk(3'b101, 0, 0, 32'h80000000, 32'h21, 5'd0, 5'd4), 32'h40000000);
    directed("illegal_sll_f7", mk(3'b001, 1, 1, 32'hFFFFFFFF, 32'h0, 5'd3, 5'd5), 32'h0);
    check("illegal_flag", out_illegal, 1);

    // Backpressure: third op must wait until the buffer drains.
    drain();
    cycle(1, rand_op(), 0, a);
    cycle(1, rand_op(), 0, a);
    o = rand_op();
    cycle(1, o, 0, a);
    check("third_blocked", a, 0);
    cycle(1, o, 0, a);
    check("still_blocked", a, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, o, 1, a);
      if (a) break;
    end
    check("third_accepted", a, 1);
    drain();

    // Streaming at full rate.
    for (int i = 0; i < 100; i++) begin
      cycle(1, rand_op(), 1, a);
      check("stream_accept", a, 1);
    end
    drain();

    // Illegal encodings interleaved with legal ones.
    cycle(1, mk(3'b101, 0, 1, 32'hF0F0F0F0, 0, 5'd4, 5'd10), 1, a);
    cycle(1, mk(3'b001, 1, 0, 32'h12345678, 32'd3, 0, 5'd11), 1, a);
    cycle(1, mk(3'b000, 0, 0, 32'h12345678, 32'd3, 0, 5'd12), 1, a);
    cycle(1, mk(3'b001, 0, 1, 32'h0000FFFF, 0, 5'd8, 5'd13), 1, a);
    drain();

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 2) != 0, a);
    drain();

    // Reset while full.
    cycle(1, rand_op(), 0, a);
    cycle(1, rand_op(), 0, a);
    cycle(0, idle_op, 0, a);
    check("full_before_reset", q.size(), 2);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_result", out_result, 0);
    q.delete();
    hold = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) cycle(0, idle_op, 1, a);
    directed("post_reset", mk(3'b001, 0, 1, 32'h00000003, 0, 5'd30, 5'd31), 32'hC0000000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execute-stage wrapper around the existing barrel_shift_right datapath.
- Decodes RISC-V RV32I shift operations: SLL, SRL, SRA, SLLI, SRLI, SRAI.
- Selects the shift amount and drives the shifter; left shifts are produced by bit-reversing the operand and the result.
- Registers results into a 2-entry skid buffer with valid/ready handshakes on both sides. Upstream is the decode/issue stage; downstream is writeback.

Parameters:
- XLEN, 32, datapath width.
- SHW, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  stage can accept an op this cycle.
- funct3  input  3  RISC-V funct3: 001 = SLL, 101 = SRL/SRA.
- funct7_5  input  1  instruction bit 30: 1 = arithmetic (SRA).
- is_imm  input  1  1 = shamt from imm_shamt, 0 = from rs2_data[SHW-1:0].
- rs1_data  input  XLEN  operand to shift.
- rs2_data  input  XLEN  register shift source; only the low SHW bits are used.
- imm_shamt  input  SHW  immediate shift amount.
- rd_addr  input  5  destination register tag, passed through.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_result  output  XLEN  shifted value.
- out_rd  output  5  destination tag.
- out_illegal  output  1  the op was not a legal shift encoding.

Behaviour:
- **Reset (async, rst_n = 0):**
  - Both buffer entries are cleared.
  - out_valid = 0, out_result = 0, out_rd = 0, out_illegal = 0.
  - in_ready = 1 on the first cycle after deassertion.
- **Handshakes:**
  - Accept when in_valid & in_ready.
  - Retire when out_valid & out_ready.
  - Inputs are sampled only on accept.
- **Decode:**
  - Shift amount: shamt = is_imm ? imm_shamt : rs2_data[SHW-1:0].
  - funct3 = 001 with funct7_5 = 0: left shift.
  - funct3 = 101: right shift; arith = funct7_5.
  - Any other combination (including 001 with funct7_5 = 1) is illegal. Illegal ops are still accepted and retired in order, with out_illegal = 1 and out_result = 0.
- **Left shift:**
  - Operand = bitrev(rs1_data), shifter runs with arith = 0, result = bitrev(shifter output).
  - Uses the same single shifter instance.
- **Latency:** 1 cycle. An op accepted at edge N appears at out_* after edge N if the buffer was empty.
- **Skid buffer (2 entries, head = output entry):**
  - States: EMPTY, ONE, FULL.
  - in_ready = (state != FULL). It is registered and does not depend combinationally on out_ready.
  - EMPTY + accept -> ONE.
  - ONE + accept, no retire -> FULL.
  - ONE + accept + retire -> ONE; the new entry becomes head.
  - ONE + retire, no accept -> EMPTY.
  - FULL + retire -> ONE; the skid entry moves to head. No accept is possible in FULL.
- **Output stability:** out_result, out_rd and out_illegal stay stable while out_valid = 1 and out_ready = 0.
- **Ordering:** results retire in acceptance order, with no drops and no duplicates.
- **Shift boundaries:**
  - shamt = 0 passes rs1 unchanged.
  - shamt = 31 with SRA yields all sign bits.
  - rs2 bits above SHW are ignored: rs2 = 0x21 shifts by 1.
- **Reset mid-operation:** all pending entries are discarded immediately; no partial result is ever presented.

Decomposition:
- Shared package (e.g. rv_pkg) holds:
  - Funct3 constants F3_SLL = 3'b001 and F3_SRL_SRA = 3'b101.
  - The XLEN default.
  - A struct/typedef for the buffer entry {result, rd, illegal}.
- One sub-module, the existing barrel_shift_right #(XLEN, SHW), instantiated once.
- Bit reversal and the buffer stay inline.

Test Plan:
1. Reset, then SRAI with rs1 = 0x80000010 and imm = 4, out_ready = 1 -> 1 cycle later out_valid = 1, out_result = 0xF8000001, out_rd echoed.
2. SLL with rs1 = 0x00000001, rs2 = 0xFFFFFFE1 (shamt = 1) -> out_result = 0x00000002. Then SRL with rs1 = 0x7AFAFAFA and shamt = 31 -> 0x00000000.
3. out_ready held at 0 while three ops are offered -> two are accepted, in_ready = 0 after the second, out_* stay stable. Release out_ready -> results retire in order and the third op is accepted.
4. Continuous in_valid = out_ready = 1 over 100 random ops -> one result per cycle, matching a reference model, in_ready stays 1.
5. funct3 = 001 with funct7_5 = 1, then funct3 = 000 -> both retire with out_illegal = 1, out_result = 0, in order among neighbouring legal ops.
6. Assert rst_n = 0 while FULL -> out_valid drops to 0 asynchronously, in_ready = 1 after release, and no stale result appears.
